// File: rtl/hidden_ram_arbiter.sv
// hidden_ram_arbiter
//   Round-robin arbiter and sequencer for the single-port hidden-unit RAM.
//   The RAM has a registered read address and one cycle of read latency. The
//   hidden-layer producer (A) and the output-layer consumer (B) share the RAM.
//   Requesters may hold ownership for locked bursts of up to MAX_BURST grants.
//   An optional clear sweep writes zero to every RAM entry. The sweep is
//   compiled in only when HIDDEN_RAM_ARB_CLEAR_EN is defined. Without it,
//   clr_start is ignored and clr_busy is tied low.
//
// Ports
//   clk, rst_n                    clock and asynchronous active-low reset
//   a_*/b_* req,we,lock,addr,wdata  requester transaction inputs
//   a_gnt, b_gnt                  combinational grant, one-cycle transaction
//   a_rvalid, b_rvalid            read data valid on rdata, one cycle after grant
//   rdata                         ram_q passed through (0 while in reset)
//   clr_start, clr_busy           clear sweep start pulse and sweep status
//   ram_data, ram_addr, ram_we    RAM drive
//   ram_q                         RAM read data
module hidden_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_t;

  owner_t                owner;
  logic                  rr_ptr;      // last granted: 0 = A, 1 = B
  logic [BW-1:0]         burst_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_data;
  logic                  clearing;
  logic                  clr_enter;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  gnt_any;
  logic                  gnt_lock;
  logic                  from_owner;
  logic [BW-1:0]         burst_base;
  logic [BW-1:0]         burst_next;
  logic                  keep_owner;

`ifdef HIDDEN_RAM_ARB_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_t;
  clr_state_t clr_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
      clr_busy  <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (clr_start) begin
            clr_state <= CLR_SWEEP;
            clr_busy  <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (clr_addr == '1) begin
            clr_state <= CLR_IDLE;
            clr_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clearing  = (clr_state == CLR_SWEEP);
  assign clr_enter = (clr_state == CLR_IDLE) && clr_start;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
  assign clearing  = 1'b0;
  assign clr_enter = 1'b0;
  assign clr_addr  = '0;
  assign clr_busy  = 1'b0;
`endif

  // Owner first. An owner that drops its request falls through to normal
  // arbitration, so the other side can win in the same cycle.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n && !clearing) begin
      if (owner == OWN_A && a_req)      a_gnt = 1'b1;
      else if (owner == OWN_B && b_req) b_gnt = 1'b1;
      else if (a_req && b_req) begin
        if (rr_ptr) a_gnt = 1'b1;
        else        b_gnt = 1'b1;
      end
      else if (a_req) a_gnt = 1'b1;
      else if (b_req) b_gnt = 1'b1;
    end
  end

  // A grant to a non-owner starts a fresh burst count. The count is never
  // inherited from a requester that just released ownership.
  always_comb begin
    gnt_any    = a_gnt | b_gnt;
    gnt_lock   = a_gnt ? a_lock : b_lock;
    from_owner = (a_gnt && owner == OWN_A) || (b_gnt && owner == OWN_B);
    burst_base = from_owner ? burst_cnt : '0;
    burst_next = burst_base + BW'(1);
    keep_owner = gnt_lock && (32'(burst_next) < MAX_BURST);
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = last_addr;
    ram_data = last_data;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_data = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_data = b_wdata;
    end else if (clearing) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr;
      ram_data = '0;
    end
  end

  assign rdata = rst_n ? ram_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= OWN_NONE;
      burst_cnt <= '0;
      rr_ptr    <= 1'b1;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (gnt_any) rr_ptr <= b_gnt;
      if (clr_enter || !gnt_any || !keep_owner) begin
        owner     <= OWN_NONE;
        burst_cnt <= '0;
      end else begin
        owner     <= a_gnt ? OWN_A : OWN_B;
        burst_cnt <= burst_next;
      end
      if (gnt_any || clearing) begin
        last_addr <= ram_addr;
        last_data <= ram_data;
      end
    end
  end

endmodule

// File: doc/hidden_ram_arbiter.md
# hidden_ram_arbiter

Two-port arbiter and sequencer for the single-port hidden-unit RAM, which has a registered read address and one-cycle read latency. It shares the RAM between the hidden-layer producer (requester A) and the output-layer consumer (requester B). Arbitration is round-robin, with optional locked bursts. The block also provides a clear sweep that zeroes every RAM entry, and it sits directly between the two layer engines and the RAM instance.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 5, RAM address width; depth = 2**ADDR_WIDTH
- MAX_BURST, 4, maximum consecutive locked grants to one requester (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req, b_req  in  1  transaction request; held until granted
- a_we, b_we  in  1  1 = write, 0 = read
- a_lock, b_lock  in  1  request to keep ownership for the following cycle
- a_addr, b_addr  in  ADDR_WIDTH  transaction address
- a_wdata, b_wdata  in  DATA_WIDTH  write data
- a_gnt, b_gnt  out  1  transaction accepted this cycle
- a_rvalid, b_rvalid  out  1  read data valid on rdata
- rdata  out  DATA_WIDTH  ram_q passed through
- clr_start  in  1  start clear sweep (pulse)
- clr_busy  out  1  clear sweep in progress
- ram_data  out  DATA_WIDTH  to RAM data
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_we  out  1  to RAM we
- ram_q  in  DATA_WIDTH  from RAM q

## Operation
- A grant is a one-cycle transaction. In a grant cycle, ram_addr, ram_data and ram_we are driven from the granted requester, and ram_we = x_we.
- Grants are combinational from the current requests and the registered state. At most one grant is asserted per cycle.
- Registered state:
  - rr_ptr: last-granted requester.
  - owner: NONE, A or B.
  - burst_cnt
  - clear FSM
  - per-requester read-pending flag
- Arbitration, evaluated when not clearing:
  - If owner = X and x_req = 1, grant X.
  - Otherwise, with one requester asserted, grant it.
  - Otherwise, with both asserted, grant the one not equal to rr_ptr.
- On each grant:
  - rr_ptr takes the granted requester.
  - If x_lock = 1 and burst_cnt+1 < MAX_BURST: owner takes X and burst_cnt increments.
  - Else: owner takes NONE and burst_cnt clears.
- Ownership release:
  - If the owner drops x_req, owner takes NONE and the other requester may be granted in that same cycle.
  - While owner = X, the other requester is never granted.
- Idle cycles (no grant, no clear): ram_we = 0; ram_addr and ram_data hold their last values.
- Read return: x_rvalid is set for exactly one cycle following a read grant to X, and rdata = ram_q in that cycle. Writes never produce rvalid.
- Clear FSM states: IDLE, CLEAR.
  - IDLE to CLEAR when clr_start = 1.
  - In CLEAR, each cycle writes 0 to clr_addr (ram_we = 1), and clr_addr increments from 0.
  - CLEAR to IDLE after writing address 2**ADDR_WIDTH−1; the counter wraps to 0.
  - clr_start is ignored while in CLEAR.
- Clear boundary cases:
  - A grant in the same cycle as clr_start completes, and its rvalid is still delivered during the first CLEAR cycle.
  - Entering CLEAR forces owner = NONE and burst_cnt = 0.
  - rr_ptr is preserved across the sweep.
  - No grants are issued in CLEAR; requests stay pending.
- Reset values:
  - All gnt, rvalid and ram_we = 0.
  - ram_addr, ram_data and rdata = 0.
  - clr_busy = 0.
  - owner = NONE, burst_cnt = 0, rr_ptr = B (so A wins the first tie).
  - Reset asserted mid-burst or mid-clear aborts immediately. Outputs are forced to reset values while rst_n = 0.

## Timing
- Grant latency: 0 cycles; gnt is asserted in the same cycle as req when the block is free.
- Read latency: x_rvalid and rdata are valid 1 cycle after the grant.
- Write: takes effect at the rising edge that ends the grant cycle.
- Back-to-back reads by one requester: 1 per cycle, rvalid pipelined.
- Clear sweep: clr_busy is high for exactly 2**ADDR_WIDTH cycles, starting the cycle after clr_start.
- A locked burst holds for at most MAX_BURST consecutive grants.

## Configuration
- HIDDEN_RAM_ARB_CLEAR_EN defined: clear FSM and clr_addr counter are compiled in, behaving as in Operation.
- HIDDEN_RAM_ARB_CLEAR_EN undefined: clr_start is ignored and clr_busy is tied to 0. The clear FSM and clr_addr counter are not built. Ports are unchanged.

## Test plan
- Reset: drop rst_n during an A lock burst → all outputs 0 within the same cycle. After release, simultaneous A and B requests grant A first.
- A writes 0x5A to addr 3; next cycle B reads addr 3 → b_gnt in that cycle, b_rvalid = 1 and rdata = 0x5A one cycle later, a_rvalid stays 0.
- A and B both request continuously, locks = 0 → grant sequence A, B, A, B over 4 cycles.
- MAX_BURST = 4, a_lock = 1, b_req held → four consecutive a_gnt, then b_gnt on the fifth cycle. A dropping a_req after 2 grants → B granted in that same cycle.
- clr_start with CLEAR_EN defined → 32 cycles of clr_busy with ram_we = 1 at addrs 0..31 and data 0. Requests are blocked during the sweep. Subsequent reads of addrs 3 and 31 return 0.
- clr_start in the same cycle as a B read grant of addr 3 (holding 0x5A) → b_rvalid with 0x5A in the first CLEAR cycle, then the sweep proceeds normally.
